// File: rtl/led_flag_stretcher.sv
// Multi-channel LED status stretcher: turns single-cycle strobes into held, latched
// or blinking indicator levels, with a saturating accepted-event counter per channel.
module led_flag_stretcher #(
   parameter int NB_CH       = 4,
   parameter int HOLD_CYCLES = 100000000,
   parameter int BLINK_HALF  = 12500000,
   parameter int NB_CNT      = 8
) (
   input  logic                      clk100,
   input  logic                      i_resetn,
   input  logic                      i_enb,
   input  logic [NB_CH-1:0]          i_evt,
   input  logic [NB_CH-1:0]          i_clr,
   input  logic [2*NB_CH-1:0]        i_mode,
   output logic [NB_CH-1:0]          o_flag,
   output logic [NB_CH-1:0]          o_led,
   output logic [NB_CH*NB_CNT-1:0]   o_evt_cnt
);

   localparam int HOLD_W  = $clog2(HOLD_CYCLES);
   localparam int BLINK_W = $clog2(BLINK_HALF + 1);

   localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_HALF - 1);
   localparam logic [NB_CNT-1:0]  CNT_MAX    = '1;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_LATCH   = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      LATCHED = 2'd2
   } state_t;

   for (genvar g = 0; g < NB_CH; g++) begin : g_ch
      state_t             state;
      logic [HOLD_W-1:0]  hold_tmr;
      logic [BLINK_W-1:0] blink_tmr;
      logic               phase;
      logic [NB_CNT-1:0]  cnt;
      logic               flag;
      logic               led;

      logic [1:0] mode;
      logic       accept;
      logic       retrig;
      logic       count_evt;
      logic       phase_nxt;

      assign mode   = i_mode[2*g +: 2];
      assign accept = i_enb & i_evt[g] & ~i_clr[g];
      assign retrig = accept & (mode != MODE_ONESHOT);
      // One-shot ignores events only while its hold timer is running.
      assign count_evt = accept & ((state != ACTIVE) | (mode != MODE_ONESHOT));
      assign phase_nxt = (blink_tmr == '0) ? ~phase : phase;

      always_ff @(posedge clk100) begin
         if (!i_resetn || i_clr[g]) begin
            state     <= IDLE;
            hold_tmr  <= '0;
            blink_tmr <= '0;
            phase     <= 1'b0;
            cnt       <= '0;
            flag      <= 1'b0;
            led       <= 1'b0;
         end else begin
            if (count_evt && (cnt != CNT_MAX))
               cnt <= cnt + 1'b1;

            case (state)
               IDLE: begin
                  if (accept) begin
                     flag <= 1'b1;
                     led  <= 1'b1;
                     if (mode == MODE_LATCH) begin
                        state <= LATCHED;
                     end else begin
                        state     <= ACTIVE;
                        hold_tmr  <= HOLD_LOAD;
                        blink_tmr <= BLINK_LOAD;
                        phase     <= 1'b1;
                     end
                  end
               end

               ACTIVE: begin
                  if (mode == MODE_LATCH) begin
                     state     <= LATCHED;
                     hold_tmr  <= '0;
                     blink_tmr <= '0;
                     phase     <= 1'b0;
                     led       <= 1'b1;
                  end else if ((hold_tmr == '0) && !retrig) begin
                     state     <= IDLE;
                     blink_tmr <= '0;
                     phase     <= 1'b0;
                     flag      <= 1'b0;
                     led       <= 1'b0;
                  end else begin
                     // Blink phase free-runs across retriggers; only the hold timer reloads.
                     hold_tmr  <= retrig ? HOLD_LOAD : hold_tmr - 1'b1;
                     blink_tmr <= (blink_tmr == '0) ? BLINK_LOAD : blink_tmr - 1'b1;
                     phase     <= phase_nxt;
                     led       <= (mode == MODE_BLINK) ? phase_nxt : 1'b1;
                  end
               end

               LATCHED: begin
                  if (mode != MODE_LATCH) begin
                     state     <= ACTIVE;
                     hold_tmr  <= HOLD_LOAD;
                     blink_tmr <= BLINK_LOAD;
                     phase     <= 1'b1;
                     led       <= 1'b1;
                  end
               end

               default: begin
                  state <= IDLE;
                  flag  <= 1'b0;
                  led   <= 1'b0;
               end
            endcase
         end
      end

      assign o_flag[g]                    = flag;
      assign o_led[g]                     = led;
      assign o_evt_cnt[NB_CNT*g +: NB_CNT] = cnt;
   end

endmodule

// File: doc/led_flag_stretcher.md
Name: led_flag_stretcher

Overview:
- Multi-channel status-indicator engine that turns single-cycle control strobes (run_log, read_log, mem_full, enable edges, …) into human-visible LED activity.
- Generalises the fixed 1-second run/read flag timers in the board top level:
  - NB_CH channels
  - parametrised hold time
  - per-channel mode: one-shot, retriggerable, blink, latched
  - per-channel saturating event counters, readable through the register file
- Sits between the register file / MEMLog strobes and the o_led / o_led_RGB pins.

Parameters:
- NB_CH, 4, number of independent channels
- HOLD_CYCLES, 100000000, active time after an accepted event (1 s at 100 MHz); must be >= 2
- BLINK_HALF, 12500000, half-period in cycles of the blink waveform (8 Hz toggle); must be >= 1
- NB_CNT, 8, width of each saturating event counter

Ports:
- clk100  input  1  system clock
- i_resetn  input  1  reset, synchronous, active-low
- i_enb  input  1  global event-accept enable; timers keep running when low
- i_evt  input  NB_CH  per-channel event strobe, level-sampled every edge
- i_clr  input  NB_CH  per-channel clear: flag, timer, blink phase and counter
- i_mode  input  2*NB_CH  channel k mode at [2k+1:2k]: 0 one-shot, 1 retrigger, 2 blink, 3 latched
- o_flag  output  NB_CH  channel active status
- o_led  output  NB_CH  LED drive (o_flag, blink-modulated in mode 2)
- o_evt_cnt  output  NB_CH*NB_CNT  channel k accepted-event count at [NB_CNT*(k+1)-1 : NB_CNT*k]

Behaviour:
- Reset (i_resetn low at an edge): o_flag, o_led, o_evt_cnt, all timers and blink phases go to 0 on that edge, regardless of any other input, including mid-hold.
- All outputs are registered; no combinational path from inputs to outputs.
- Hold timer width is $clog2(HOLD_CYCLES); blink timer width is $clog2(BLINK_HALF+1).
- Accept condition, channel k: i_enb & i_evt[k] & ~i_clr[k], further qualified by mode below.
- Per-channel states:
  - IDLE (o_flag=0)
  - ACTIVE (o_flag=1, timer running)
  - LATCHED (o_flag=1, no timer)
- IDLE -> ACTIVE or LATCHED:
  - On the edge an event is accepted, o_flag rises.
  - Modes 0/1/2 go to ACTIVE; mode 3 goes to LATCHED.
- ACTIVE hold:
  - o_flag stays high for exactly HOLD_CYCLES cycles after the accepting edge, then returns to IDLE on edge t+HOLD_CYCLES.
  - An event held high continuously counts once per accepting edge.
- Event while ACTIVE:
  - Mode 0: ignored; timer not reloaded; counter not incremented.
  - Modes 1/2: accepted; timer reloads, so the hold ends HOLD_CYCLES after the last accepting edge; counter increments.
- LATCHED: stays until i_clr[k]. Further events increment the counter only.
- Blink (mode 2):
  - Blink phase is set to 1 on the edge that accepts from IDLE.
  - Phase toggles every BLINK_HALF cycles while ACTIVE and is not reset by retriggers.
  - o_led[k] = o_flag[k] & phase.
- Other modes: o_led[k] = o_flag[k].
- Clear: i_clr[k] at an edge forces IDLE, timer = 0, phase = 0, counter = 0. Clear wins over a simultaneous event.
- Mode change while ACTIVE: new mode applies from the next edge; the running timer is not restarted.
  - Switching to mode 3 while ACTIVE moves to LATCHED.
  - Switching from 3 to 0/1/2 while LATCHED loads a fresh HOLD_CYCLES timer.
- Counter: increments by 1 per accepted event, saturates at 2^NB_CNT-1 (no wrap). Increment happens on the same edge as the flag update.
- i_enb low: no events accepted, counters frozen. ACTIVE timers still expire and blink still runs.
- Channels are fully independent; events on all NB_CH channels in the same cycle are all processed that cycle.

Test Plan:
(All scenarios use NB_CH=4, HOLD_CYCLES=10, BLINK_HALF=2, NB_CNT=4.)
- Reset mid-hold: ch0 mode 0, 1-cycle evt at edge 5, i_resetn low at edge 9 -> o_flag[0], o_led[0], o_evt_cnt all 0 after edge 9.
- One-shot: ch0 mode 0, evt at edges 5 and 8 -> o_flag[0] high edges 5..14 (10 cycles), falls at edge 15, o_evt_cnt[0]=1.
- Retrigger: ch1 mode 1, evt at edges 5 and 12 -> o_flag[1] falls at edge 22, o_evt_cnt[1]=2. Evt held high 20 cycles -> count saturates at 15.
- Blink: ch2 mode 2, evt at edge 0 -> o_led[2] pattern 1,1,0,0,1,1,0,0,1,1 over edges 0..9, then 0. o_flag[2] high for 10 cycles.
- Latched plus clear priority: ch3 mode 3, evt at edge 2 -> o_flag[3] stays high 100 cycles. i_clr[3] and i_evt[3] both high at edge 102 -> o_flag[3]=0, o_evt_cnt[3]=0.
- Enable gating and independence: i_enb=0, evt on all channels -> no change. i_enb=1, simultaneous evt on ch0..3 in modes 0..3 -> all o_flag rise on the same edge, each count = 1.
